// File: rtl/rcv_bit_decoder_if.sv
// rcv_bit_decoder_if: sampled-line inputs and decoded byte/error pulse outputs of the bit decoder.
interface rcv_bit_decoder_if #(parameter int DATA_W = 8);
  logic d_plus_sync;
  logic shift_strobe;
  logic transfer_active;
  logic [DATA_W-1:0] rx_byte;
  logic byte_valid;
  logic stuff_skip;
  logic stuff_err;
  logic align_err;
  modport master (
    output d_plus_sync, shift_strobe, transfer_active,
    input rx_byte, byte_valid, stuff_skip, stuff_err, align_err
  );
  modport slave (
    input d_plus_sync, shift_strobe, transfer_active,
    output rx_byte, byte_valid, stuff_skip, stuff_err, align_err
  );
endinterface

// File: rtl/rcv_bit_decoder.sv
// rcv_bit_decoder: NRZI decode, bit-unstuffing and LSB-first byte assembly on each sample strobe.
module rcv_bit_decoder #(
  parameter int DATA_W = 8,
  parameter int STUFF_LEN = 6
) (
  input logic clk,
  input logic rst,
  rcv_bit_decoder_if.slave bus
);
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int BW = $clog2(DATA_W);
  localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
  state_t state;
  logic prev_level;
  logic [OW-1:0] ones_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic bit_in;
  logic [DATA_W-1:0] shreg_next;
  assign bit_in = bus.d_plus_sync == prev_level;
  assign shreg_next = {bit_in, shreg[DATA_W-1:1]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prev_level <= 1'b1;
      ones_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      bus.rx_byte <= '0;
      bus.byte_valid <= 1'b0;
      bus.stuff_skip <= 1'b0;
      bus.stuff_err <= 1'b0;
      bus.align_err <= 1'b0;
    end else begin
      bus.byte_valid <= 1'b0;
      bus.stuff_skip <= 1'b0;
      bus.stuff_err <= 1'b0;
      bus.align_err <= 1'b0;
      if (state == IDLE) begin
        prev_level <= 1'b1;
        ones_cnt <= '0;
        bit_cnt <= '0;
        if (bus.transfer_active) state <= RUN;
      end else if (!bus.transfer_active) begin
        state <= IDLE;
        prev_level <= 1'b1;
        ones_cnt <= '0;
        bit_cnt <= '0;
        bus.align_err <= state == RUN && bit_cnt != '0;
      end else if (state == RUN && bus.shift_strobe) begin
        prev_level <= bus.d_plus_sync;
        if (ones_cnt == STUFF_MAX) begin
          // After a full run of ones the next bit must be the stuffed zero
          ones_cnt <= '0;
          if (bit_in) begin
            bus.stuff_err <= 1'b1;
            state <= ERR;
          end else begin
            bus.stuff_skip <= 1'b1;
          end
        end else begin
          ones_cnt <= bit_in ? ones_cnt + 1'b1 : '0;
          shreg <= shreg_next;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            bus.rx_byte <= shreg_next;
            bus.byte_valid <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_rcv_bit_decoder.sv
// tb_rcv_bit_decoder: directed and randomized packets checked every cycle against a queue-based model.
module tb_rcv_bit_decoder;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  int n_valid = 0, n_skip = 0, n_serr = 0, n_align = 0;
  rcv_bit_decoder_if #(.DATA_W(8)) bus ();
  rcv_bit_decoder #(.DATA_W(8), .STUFF_LEN(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  bit m_active, m_bad, m_level;
  int m_ones;
  int m_q[$];
  logic [7:0] m_byte;
  logic [7:0] e_byte;
  logic e_valid, e_skip, e_serr, e_align;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_active = 0; m_bad = 0; m_level = 1; m_ones = 0; m_q.delete();
    m_byte = 8'h00; e_byte = 8'h00;
    e_valid = 0; e_skip = 0; e_serr = 0; e_align = 0;
  endtask
  task automatic model_step();
    bit b;
    e_valid = 0; e_skip = 0; e_serr = 0; e_align = 0;
    if (rst) begin
      model_reset();
    end else if (!m_active) begin
      m_active = bus.transfer_active;
    end else if (!bus.transfer_active) begin
      e_align = !m_bad && m_q.size() != 0;
      m_active = 0; m_bad = 0; m_level = 1; m_ones = 0; m_q.delete();
    end else if (!m_bad && bus.shift_strobe) begin
      b = bus.d_plus_sync == m_level;
      m_level = bus.d_plus_sync;
      if (m_ones == 6) begin
        m_ones = 0;
        if (b) begin m_bad = 1; e_serr = 1; end
        else e_skip = 1;
      end else begin
        m_ones = b ? m_ones + 1 : 0;
        m_q.push_back(int'(b));
        if (m_q.size() == 8) begin
          m_byte = 8'h00;
          for (int i = 0; i < 8; i++) m_byte = m_byte | (8'(m_q[i]) << i);
          m_q.delete();
          e_valid = 1;
        end
      end
    end
    e_byte = m_byte;
  endtask
  always @(negedge clk) begin
    if (rst) model_reset();
    chk("rx_byte", {24'h0, bus.rx_byte}, {24'h0, e_byte});
    chk("byte_valid", {31'h0, bus.byte_valid}, {31'h0, e_valid});
    chk("stuff_skip", {31'h0, bus.stuff_skip}, {31'h0, e_skip});
    chk("stuff_err", {31'h0, bus.stuff_err}, {31'h0, e_serr});
    chk("align_err", {31'h0, bus.align_err}, {31'h0, e_align});
    n_valid += int'(bus.byte_valid);
    n_skip += int'(bus.stuff_skip);
    n_serr += int'(bus.stuff_err);
    n_align += int'(bus.align_err);
    model_step();
  end
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic strobe(input logic lvl);
    bus.d_plus_sync = lvl;
    bus.shift_strobe = 1'b1;
    tick();
    bus.shift_strobe = 1'b0;
    tick();
  endtask
  task automatic send_a5();
    logic [7:0] lv;
    lv = 8'b1100_1001;
    for (int i = 0; i < 8; i++) strobe(lv[i]);
  endtask
  int v0, s0, e0, a0;
  logic lvl;
  initial begin
    rst = 1'b1;
    bus.d_plus_sync = 1'b1;
    bus.shift_strobe = 1'b0;
    bus.transfer_active = 1'b0;
    model_reset();
    tick(3);
    chk("reset_byte", {24'h0, bus.rx_byte}, 32'h0);
    rst = 1'b0;
    tick(2);
    v0 = n_valid; s0 = n_skip; e0 = n_serr; a0 = n_align;
    strobe(1'b0);
    strobe(1'b1);
    tick(2);
    chk("idle_strobe_pulses", n_valid + n_skip + n_serr + n_align - v0 - s0 - e0 - a0, 0);
    bus.transfer_active = 1'b1;
    tick(2);
    v0 = n_valid; s0 = n_skip;
    send_a5();
    tick(2);
    chk("a5_byte", {24'h0, bus.rx_byte}, 32'hA5);
    chk("a5_model", {24'h0, m_byte}, 32'hA5);
    chk("a5_valid_cnt", n_valid - v0, 1);
    chk("a5_skip_cnt", n_skip - s0, 0);
    a0 = n_align;
    strobe(1'b0); strobe(1'b1); strobe(1'b0);
    bus.transfer_active = 1'b0;
    tick(3);
    chk("align_cnt", n_align - a0, 1);
    chk("align_byte_held", {24'h0, bus.rx_byte}, 32'hA5);
    chk("align_valid_cnt", n_valid - v0, 1);
    bus.transfer_active = 1'b1;
    tick(2);
    v0 = n_valid; s0 = n_skip; a0 = n_align;
    repeat (6) strobe(1'b1);
    repeat (3) strobe(1'b0);
    tick(2);
    chk("ff_byte", {24'h0, bus.rx_byte}, 32'hFF);
    chk("ff_skip_cnt", n_skip - s0, 1);
    chk("ff_valid_cnt", n_valid - v0, 1);
    bus.transfer_active = 1'b0;
    tick(3);
    chk("ff_no_align", n_align - a0, 0);
    bus.transfer_active = 1'b1;
    tick(2);
    v0 = n_valid; e0 = n_serr; a0 = n_align;
    repeat (7) strobe(1'b1);
    repeat (10) strobe(1'b0);
    chk("serr_cnt", n_serr - e0, 1);
    chk("serr_no_byte", n_valid - v0, 0);
    bus.transfer_active = 1'b0;
    tick(3);
    chk("serr_no_align", n_align - a0, 0);
    bus.transfer_active = 1'b1;
    tick(2);
    strobe(1'b0); strobe(1'b0); strobe(1'b1);
    rst = 1'b1;
    tick();
    chk("midrst_byte", {24'h0, bus.rx_byte}, 32'h0);
    rst = 1'b0;
    bus.transfer_active = 1'b0;
    tick(2);
    bus.transfer_active = 1'b1;
    tick(2);
    send_a5();
    tick(2);
    chk("post_rst_a5", {24'h0, bus.rx_byte}, 32'hA5);
    bus.transfer_active = 1'b0;
    tick(3);
    for (int p = 0; p < 200; p++) begin
      bus.transfer_active = 1'b1;
      tick($urandom_range(1, 2));
      lvl = 1'($urandom_range(0, 1));
      for (int k = 0; k < int'($urandom_range(0, 30)); k++) begin
        if ($urandom_range(0, 3) == 0) lvl = ~lvl;
        bus.d_plus_sync = lvl;
        bus.shift_strobe = 1'b1;
        if ($urandom_range(0, 39) == 0) begin
          bus.transfer_active = 1'b0;
          break;
        end
        tick();
        bus.shift_strobe = 1'b0;
        if ($urandom_range(0, 99) == 0) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
        end
        tick($urandom_range(0, 2));
      end
      bus.transfer_active = 1'b0;
      tick();
      bus.shift_strobe = 1'b0;
      tick($urandom_range(1, 3));
    end
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rcv_bit_decoder.md
Name: rcv_bit_decoder

Overview:
Receive-path stage directly downstream of the receive bit timer, which produces the per-bit sample strobe.
- On each sample strobe, performs NRZI decode of the synchronized D+ line, removes USB stuffed bits and assembles LSB-first bytes.
- Delivers each completed byte with a one-cycle valid pulse, plus error pulses, to the receive control FSM and the RX FIFO.

Parameters:
DATA_W, 8, byte width in accepted (unstuffed) bits
STUFF_LEN, 6, consecutive decoded ones after which the next bit is a stuffed zero

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
d_plus_sync  input  1  metastability-synchronized D+ level
shift_strobe  input  1  one-cycle sample pulse from the bit timer, at most one per bit period
transfer_active  input  1  high while a packet is being received
rx_byte  output  DATA_W  last completed byte, LSB = first received bit
byte_valid  output  1  one-cycle pulse, rx_byte updated this cycle
stuff_skip  output  1  one-cycle pulse, current strobe bit discarded as stuffed zero
stuff_err  output  1  one-cycle pulse, stuff violation detected
align_err  output  1  one-cycle pulse, packet ended mid-byte

Behaviour:
- Reset (async, rst=1): state IDLE, prev_level=1, ones_cnt=0, bit_cnt=0, shreg=0, rx_byte=0, all pulse outputs 0.
- FSM states: IDLE, RUN, ERR.
- IDLE -> RUN when transfer_active=1.
- RUN -> ERR on stuff violation.
- RUN or ERR -> IDLE when transfer_active=0.
- In IDLE: prev_level held at 1 (idle J), ones_cnt=0, bit_cnt=0; strobes ignored.
- NRZI decode, evaluated on every strobe in RUN:
  - bit = 1 if d_plus_sync == prev_level, else 0.
  - prev_level <= d_plus_sync.
- Stuff handling in RUN:
  - If ones_cnt == STUFF_LEN and bit == 0: bit discarded, no shift, ones_cnt <= 0, stuff_skip pulses the next cycle.
  - If ones_cnt == STUFF_LEN and bit == 1: stuff_err pulses the next cycle, state ERR.
  - Otherwise the bit is accepted: ones_cnt <= bit ? ones_cnt+1 : 0.
- Accepted bit:
  - shreg <= {bit, shreg[DATA_W-1:1]}, bit_cnt <= bit_cnt+1.
  - On the DATA_W-th accepted bit: rx_byte <= the new shreg value, byte_valid pulses, bit_cnt <= 0.
- Latency: all outputs register on the clk edge following the strobe cycle, i.e. valid 1 cycle after shift_strobe.
- rx_byte holds until the next byte_valid; it is not cleared on transfer end.
- ones_cnt carries across byte boundaries, so a stuffed zero can follow the last bit of a byte.
- ERR: strobes ignored, no further pulses until transfer_active=0.
- Packet end (transfer_active 1 -> 0):
  - From RUN with bit_cnt != 0: align_err pulses the next cycle.
  - In all cases: partial byte discarded, counters cleared.
  - A strobe coinciding with transfer_active=0 is ignored.
- rst asserted mid-byte: immediate return to reset values; no pulses emitted.
- Widths:
  - ones_cnt is clog2(STUFF_LEN+1) bits and saturates at STUFF_LEN, never wraps.
  - bit_cnt is clog2(DATA_W) bits and wraps to 0 exactly at DATA_W.

Test Plan:
- Reset: assert rst mid-operation -> all outputs 0, rx_byte=0x00, next packet decodes from prev_level=1.
- Byte 0xA5: transfer_active=1, d_plus_sync levels 1,0,0,1,0,0,1,1 on 8 strobes -> single byte_valid 1 cycle after the 8th strobe, rx_byte=0xA5, no stuff_skip.
- Byte 0xFF with stuffing:
  - Stimulus: level held 1 for 6 strobes, then 0 for 3 strobes.
  - Required: stuff_skip 1 cycle after the 7th strobe; byte_valid after the 9th strobe, rx_byte=0xFF.
- Stuff error: level held constant for 7 strobes -> stuff_err pulse after the 7th strobe, no byte_valid; later strobes ignored until transfer_active=0.
- Alignment: 0xA5 followed by 3 more strobes, then transfer_active=0 -> byte_valid once (0xA5), then align_err pulse; rx_byte stays 0xA5.
- Ignored strobe: shift_strobe pulsed with transfer_active=0 -> no outputs; prev_level remains 1.
